// File: rtl/threshold_pkg.sv
// Shared types for the threshold-to-BMP path: pixel-pair packing, scheduler
// states and the BMP header size used by the writer stage.
package threshold_pkg;

  localparam int BMP_HEADER_NUMBER = 54;
  localparam int PIXEL_PAIR_W      = 48;

  // First field lands in the MSBs, so a cast from the 48-bit bus keeps R_even on top.
  typedef struct packed {
    logic [7:0] red_even;
    logic [7:0] green_even;
    logic [7:0] blue_even;
    logic [7:0] red_odd;
    logic [7:0] green_odd;
    logic [7:0] blue_odd;
  } pixel_pair_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ROW,
    ST_BLANK,
    ST_DONE
  } sched_state_t;

  function automatic int index_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/frame_write_scheduler_if.sv
// Pixel-pair source handshake plus the writer-side strobe, colour buses and indices.
interface frame_write_scheduler_if #(
  parameter int COL_W = 2,
  parameter int ROW_W = 1
);
  import threshold_pkg::*;

  logic                    src_Valid;
  logic                    src_Ready;
  logic [PIXEL_PAIR_W-1:0] src_Data;
  logic                    horizontal_Pulse;
  logic [7:0]              data_Red_Even;
  logic [7:0]              data_Green_Even;
  logic [7:0]              data_Blue_Even;
  logic [7:0]              data_Red_Odd;
  logic [7:0]              data_Green_Odd;
  logic [7:0]              data_Blue_Odd;
  logic [COL_W-1:0]        col_Index;
  logic [ROW_W-1:0]        row_Index;

  modport master (
    output src_Valid, src_Data,
    input  src_Ready, horizontal_Pulse,
    input  data_Red_Even, data_Green_Even, data_Blue_Even,
    input  data_Red_Odd, data_Green_Odd, data_Blue_Odd,
    input  col_Index, row_Index
  );

  modport slave (
    input  src_Valid, src_Data,
    output src_Ready, horizontal_Pulse,
    output data_Red_Even, data_Green_Even, data_Blue_Even,
    output data_Red_Odd, data_Green_Odd, data_Blue_Odd,
    output col_Index, row_Index
  );
endinterface

// File: rtl/frame_write_scheduler_frame_counter.sv
// Column (pair) and row position counters with wrap, clear and last-position flags.
module frame_counter
  import threshold_pkg::*;
#(
  parameter int NUM_COLS = 384,
  parameter int NUM_ROWS = 512,
  parameter int COL_W    = index_width(NUM_COLS),
  parameter int ROW_W    = index_width(NUM_ROWS)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clear,
  input  logic             inc,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             last_col,
  output logic             last_row
);

  logic [COL_W-1:0] col_q, col_d;
  logic [ROW_W-1:0] row_q, row_d;

  assign last_col = (col_q == COL_W'(NUM_COLS - 1));
  assign last_row = (row_q == ROW_W'(NUM_ROWS - 1));
  assign col      = col_q;
  assign row      = row_q;

  always_comb begin
    col_d = col_q;
    row_d = row_q;
    if (clear) begin
      col_d = '0;
      row_d = '0;
    end else if (inc) begin
      if (last_col) begin
        col_d = '0;
        row_d = last_row ? '0 : row_q + ROW_W'(1);
      end else begin
        col_d = col_q + COL_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col_q <= '0;
      row_q <= '0;
    end else begin
      col_q <= col_d;
      row_q <= row_d;
    end
  end

endmodule

// File: rtl/frame_write_scheduler.sv
// Frame sequencer between the threshold core and the BMP writer: accepts pixel
// pairs in ROW, inserts blanking between rows, pulses completion after the last pair.
module frame_write_scheduler
  import threshold_pkg::*;
#(
  parameter int IMAGE_WIDTH  = 768,
  parameter int IMAGE_HEIGHT = 512,
  parameter int H_BLANK      = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    start,
  frame_write_scheduler_if.slave  bus,
  output logic                    busy,
  output logic                    sig_Frame_Done
);

  localparam int NUM_COLS = IMAGE_WIDTH / 2;
  localparam int COL_W    = index_width(NUM_COLS);
  localparam int ROW_W    = index_width(IMAGE_HEIGHT);
  localparam int BLANK_W  = index_width(H_BLANK);

  sched_state_t     state_q, state_d;
  logic [BLANK_W-1:0] blank_q, blank_d;
  pixel_pair_t      pair_q, pair_d;
  logic [COL_W-1:0] col_idx_q, col_idx_d;
  logic [ROW_W-1:0] row_idx_q, row_idx_d;
  logic             pulse_q, pulse_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             handshake;
  logic [COL_W-1:0] cnt_col;
  logic [ROW_W-1:0] cnt_row;
  logic             last_col, last_row;

  assign handshake = bus.src_Valid && (state_q == ST_ROW);

  frame_counter #(
    .NUM_COLS(NUM_COLS),
    .NUM_ROWS(IMAGE_HEIGHT),
    .COL_W   (COL_W),
    .ROW_W   (ROW_W)
  ) u_frame_counter (
    .clk     (clk),
    .reset   (reset),
    .clear   (state_q == ST_IDLE),
    .inc     (handshake),
    .col     (cnt_col),
    .row     (cnt_row),
    .last_col(last_col),
    .last_row(last_row)
  );

  always_comb begin
    state_d   = state_q;
    blank_d   = blank_q;
    pair_d    = pair_q;
    col_idx_d = col_idx_q;
    row_idx_d = row_idx_q;
    pulse_d   = 1'b0;
    busy_d    = busy_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_ROW;
          busy_d  = 1'b1;
        end
      end
      ST_ROW: begin
        if (handshake) begin
          pair_d    = pixel_pair_t'(bus.src_Data);
          col_idx_d = cnt_col;
          row_idx_d = cnt_row;
          pulse_d   = 1'b1;
          if (last_col) begin
            if (last_row) begin
              state_d = ST_DONE;
            end else if (H_BLANK > 0) begin
              state_d = ST_BLANK;
              blank_d = BLANK_W'(H_BLANK - 1);
            end
          end
        end
      end
      ST_BLANK: begin
        if (blank_q == '0) state_d = ST_ROW;
        else               blank_d = blank_q - BLANK_W'(1);
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        done_d  = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      blank_q   <= '0;
      pair_q    <= '0;
      col_idx_q <= '0;
      row_idx_q <= '0;
      pulse_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      blank_q   <= blank_d;
      pair_q    <= pair_d;
      col_idx_q <= col_idx_d;
      row_idx_q <= row_idx_d;
      pulse_q   <= pulse_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign bus.src_Ready        = (state_q == ST_ROW);
  assign bus.horizontal_Pulse = pulse_q;
  assign bus.data_Red_Even    = pair_q.red_even;
  assign bus.data_Green_Even  = pair_q.green_even;
  assign bus.data_Blue_Even   = pair_q.blue_even;
  assign bus.data_Red_Odd     = pair_q.red_odd;
  assign bus.data_Green_Odd   = pair_q.green_odd;
  assign bus.data_Blue_Odd    = pair_q.blue_odd;
  assign bus.col_Index        = col_idx_q;
  assign bus.row_Index        = row_idx_q;
  assign busy                 = busy_q;
  assign sig_Frame_Done       = done_q;

endmodule

// File: tb/tb_frame_write_scheduler.sv
// Randomised frame-level bench: two schedulers (H_BLANK=2 and H_BLANK=0) share the
// stimulus; a pair-count reference model predicts every output of the selected one.
module tb_frame_write_scheduler;
  import threshold_pkg::*;

  localparam int W = 8, H = 2, P = W / 2, TOTAL = P * H;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, valid = 1'b0;
  logic [47:0] data = '0;
  logic        busy_a, done_a, busy_b, done_b;
  int          sel = 0, hb = 2;
  int          checks = 0, errors = 0;

  always #5 clk = ~clk;

  frame_write_scheduler_if #(.COL_W(2), .ROW_W(1)) bus_a ();
  frame_write_scheduler_if #(.COL_W(2), .ROW_W(1)) bus_b ();

  assign bus_a.src_Valid = valid;
  assign bus_a.src_Data  = data;
  assign bus_b.src_Valid = valid;
  assign bus_b.src_Data  = data;

  frame_write_scheduler #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(2)) dut_a (
    .clk(clk), .reset(reset), .start(start), .bus(bus_a),
    .busy(busy_a), .sig_Frame_Done(done_a));

  frame_write_scheduler #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(H), .H_BLANK(0)) dut_b (
    .clk(clk), .reset(reset), .start(start), .bus(bus_b),
    .busy(busy_b), .sig_Frame_Done(done_b));

  // {ready, pulse, busy, done, col[1:0], row, data[47:0]}
  logic [54:0] obs_a, obs_b, obs;
  assign obs_a = {bus_a.src_Ready, bus_a.horizontal_Pulse, busy_a, done_a,
                  bus_a.col_Index, bus_a.row_Index,
                  bus_a.data_Red_Even, bus_a.data_Green_Even, bus_a.data_Blue_Even,
                  bus_a.data_Red_Odd, bus_a.data_Green_Odd, bus_a.data_Blue_Odd};
  assign obs_b = {bus_b.src_Ready, bus_b.horizontal_Pulse, busy_b, done_b,
                  bus_b.col_Index, bus_b.row_Index,
                  bus_b.data_Red_Even, bus_b.data_Green_Even, bus_b.data_Blue_Even,
                  bus_b.data_Red_Odd, bus_b.data_Green_Odd, bus_b.data_Blue_Odd};
  assign obs = (sel == 0) ? obs_a : obs_b;

  // Reference model: n pairs accepted so far, gap = blank cycles still owed,
  // fin = final pair just accepted so completion is due on the next edge.
  bit          m_ready, m_pulse, m_busy, m_done, m_idle, fin;
  logic [47:0] m_data;
  int          m_col, m_row, n, gap;

  task automatic model_edge(input bit rst, input bit st, input bit v, input logic [47:0] d);
    bit hs;
    if (rst) begin
      m_ready = 0; m_pulse = 0; m_busy = 0; m_done = 0; m_idle = 1; fin = 0;
      m_data = '0; m_col = 0; m_row = 0; n = 0; gap = 0;
      return;
    end
    hs      = v && m_ready;
    m_pulse = hs;
    m_done  = 0;
    if (fin) begin
      fin = 0; m_done = 1; m_busy = 0; m_idle = 1;
    end else if (m_idle && st) begin
      m_idle = 0; m_busy = 1; m_ready = 1; n = 0;
    end else if (hs) begin
      m_data = d; m_col = n % P; m_row = n / P; n++;
      if (n == TOTAL) begin
        m_ready = 0; fin = 1;
      end else if (n % P == 0) begin
        gap = hb; m_ready = (hb == 0);
      end
    end else if (gap > 0) begin
      gap--; m_ready = (gap == 0);
    end
  endtask

  function automatic logic [54:0] expv();
    return {m_ready, m_pulse, m_busy, m_done, 2'(m_col), 1'(m_row), m_data};
  endfunction

  task automatic step(input bit rst, input bit st, input bit v, input logic [47:0] d);
    reset = rst; start = st; valid = v; data = d;
    model_edge(rst, st, v, d);
    @(posedge clk);
    #1;
  endtask

  function automatic logic [47:0] rnd_pair(input int k);
    return {8'(k), $urandom, 8'($urandom)};
  endfunction

  // vmode: 0 always valid, 1 alternating, 2 random. stray: extra starts mid-row 0 and in DONE.
  task automatic run_frame(input string name, input int vmode, input bit stray,
                           output int len, output int pulses, output int dones, output int gaps);
    int t;
    bit v, st;
    len = 0; pulses = 0; dones = 0; gaps = 0;
    step(0, 1, 0, '0);
    t = 1;
    checks++;
    if (obs !== expv()) begin
      errors++; $display("FAIL %s start obs=%h exp=%h", name, obs, expv());
    end
    while (!m_done && t < 200) begin
      case (vmode)
        0:       v = 1'b1;
        1:       v = (t % 2 == 1);
        default: v = 1'($urandom_range(0, 1));
      endcase
      st = stray && ((n == 2) || fin);
      step(0, st, v, rnd_pair(n));
      t++;
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL %s cyc %0d obs=%h exp=%h", name, t, obs, expv());
      end
      pulses += int'(obs[53]);
      dones  += int'(obs[51]);
      if (!obs[54] && n > 0 && n < TOTAL) gaps++;
    end
    checks++;
    if (!m_done) begin
      errors++; $display("FAIL %s timeout got no done after %0d cycles need done", name, t);
    end
    len = t + 1;  // counted inclusive of the cycle in which start was sampled
    repeat (2) begin
      step(0, 0, 0, '0);
      checks++;
      if (obs !== expv()) begin
        errors++; $display("FAIL %s tail obs=%h exp=%h", name, obs, expv());
      end
      dones += int'(obs[51]);
    end
    $display("frame %s: len=%0d pulses=%0d dones=%0d gaps=%0d", name, len, pulses, dones, gaps);
  endtask

  task automatic test_reset();
    sel = 0; hb = 2;
    step(1, 0, 0, '0);
    checks++;
    if (obs_a !== 55'd0) begin errors++; $display("FAIL reset_a got %h need 0", obs_a); end
    checks++;
    if (obs_b !== 55'd0) begin errors++; $display("FAIL reset_b got %h need 0", obs_b); end
    $display("reset: obs_a=%h obs_b=%h", obs_a, obs_b);
  endtask

  task automatic test_packing();
    logic [47:0] pk;
    logic [7:0]  act[6];
    pk = 48'h112233_445566;
    sel = 0; hb = 2;
    step(1, 0, 0, '0);
    step(0, 1, 0, '0);
    step(0, 0, 1, pk);
    act = '{bus_a.data_Red_Even, bus_a.data_Green_Even, bus_a.data_Blue_Even,
            bus_a.data_Red_Odd, bus_a.data_Green_Odd, bus_a.data_Blue_Odd};
    checks++;
    if (bus_a.horizontal_Pulse !== 1'b1) begin
      errors++; $display("FAIL packing_pulse got %b need 1", bus_a.horizontal_Pulse);
    end
    for (int i = 0; i < 6; i++) begin
      checks++;
      if (act[i] !== pk[47-8*i -: 8]) begin
        errors++; $display("FAIL packing_byte%0d got %h need %h", i, act[i], pk[47-8*i -: 8]);
      end
    end
    $display("packing: %h %h %h %h %h %h", act[0], act[1], act[2], act[3], act[4], act[5]);
    step(1, 0, 0, '0);
  endtask

  task automatic test_full_rate();
    int len, p, dn, g;
    sel = 0; hb = 2;
    step(1, 0, 0, '0);
    run_frame("full_rate", 0, 0, len, p, dn, g);
    checks++; if (p != 8)   begin errors++; $display("FAIL full_pulses got %0d need 8", p); end
    checks++; if (g != 2)   begin errors++; $display("FAIL full_gap got %0d need 2", g); end
    checks++; if (dn != 1)  begin errors++; $display("FAIL full_dones got %0d need 1", dn); end
    checks++; if (len != 13) begin errors++; $display("FAIL full_len got %0d need 13", len); end
  endtask

  task automatic test_stall();
    int len, p, dn, g;
    sel = 0; hb = 2;
    step(1, 0, 0, '0);
    run_frame("stall", 1, 0, len, p, dn, g);
    checks++; if (p != 8)  begin errors++; $display("FAIL stall_pulses got %0d need 8", p); end
    checks++; if (dn != 1) begin errors++; $display("FAIL stall_dones got %0d need 1", dn); end
  endtask

  task automatic test_hblank0();
    int len, p, dn, g;
    sel = 1; hb = 0;
    step(1, 0, 0, '0);
    run_frame("hblank0", 0, 0, len, p, dn, g);
    checks++; if (p != 8)    begin errors++; $display("FAIL hb0_pulses got %0d need 8", p); end
    checks++; if (g != 0)    begin errors++; $display("FAIL hb0_gap got %0d need 0", g); end
    checks++; if (len != 11) begin errors++; $display("FAIL hb0_len got %0d need 11", len); end
  endtask

  task automatic test_random();
    int len, p, dn, g;
    for (int s = 0; s < 2; s++) begin
      sel = s; hb = (s == 0) ? 2 : 0;
      step(1, 0, 0, '0);
      repeat (3) begin
        run_frame("random", 2, 0, len, p, dn, g);
        checks++;
        if (p != 8 || dn != 1) begin
          errors++; $display("FAIL random_frame got pulses=%0d dones=%0d need 8/1", p, dn);
        end
      end
    end
  endtask

  task automatic test_start_busy();
    int len, p, dn, g;
    sel = 0; hb = 2;
    step(1, 0, 0, '0);
    run_frame("start_busy", 0, 1, len, p, dn, g);
    checks++; if (dn != 1) begin errors++; $display("FAIL busy_dones got %0d need 1", dn); end
    checks++; if (p != 8)  begin errors++; $display("FAIL busy_pulses got %0d need 8", p); end
    run_frame("after_busy", 2, 0, len, p, dn, g);
    checks++;
    if (p != 8 || dn != 1) begin
      errors++; $display("FAIL busy_second got pulses=%0d dones=%0d need 8/1", p, dn);
    end
  endtask

  task automatic test_reset_mid();
    int t, len, p, dn, g;
    for (int run = 0; run < 2; run++) begin
      sel = 0; hb = 2;
      step(1, 0, 0, '0);
      step(0, 1, 0, '0);
      t = 0;
      while (((run == 0) ? (n < 6) : (gap == 0)) && t < 50) begin
        step(0, 0, 1, rnd_pair(n));
        t++;
        checks++;
        if (obs !== expv()) begin
          errors++; $display("FAIL reset_mid%0d pre obs=%h exp=%h", run, obs, expv());
        end
      end
      step(1, 0, 0, '0);
      checks++;
      if (obs !== 55'd0) begin
        errors++; $display("FAIL reset_mid%0d got %h need 0", run, obs);
      end
      $display("reset_mid%0d: after reset obs=%h", run, obs);
      step(0, 0, 0, '0);
      run_frame("after_reset", 0, 0, len, p, dn, g);
      checks++;
      if (p != 8 || dn != 1) begin
        errors++; $display("FAIL reset_mid%0d_frame got pulses=%0d dones=%0d need 8/1", run, p, dn);
      end
    end
  endtask

  initial begin
    test_reset();
    test_packing();
    test_full_rate();
    test_stall();
    test_hblank0();
    test_random();
    test_start_busy();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/frame_write_scheduler.md
# frame_write_scheduler

Sequences pixel-pair traffic from the threshold datapath into the BMP writer stage, one frame at a time. It accepts pixel pairs over a ready/valid handshake and drives the writer's horizontal pulse and six 8-bit colour buses. It tracks column and row position, inserts a programmable blanking gap between rows, and flags frame completion. It sits between the threshold core output and the file-writer module.

## Interface
Parameters:
- IMAGE_WIDTH, 768: pixels per row; must be even and ≥ 2.
- IMAGE_HEIGHT, 512: rows per frame; must be ≥ 1.
- H_BLANK, 4: idle cycles between rows; 0 is legal.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high; clears all state.
- start  in  1  single-cycle request to begin a frame; ignored unless IDLE.
- src_Valid  in  1  upstream pixel pair valid.
- src_Ready  out  1  scheduler accepts a pair this cycle.
- src_Data  in  48  {R_even, G_even, B_even, R_odd, G_odd, B_odd}, 8 bits each, MSB first.
- horizontal_Pulse  out  1  writer strobe; high for one cycle per pair.
- data_Red_Even, data_Green_Even, data_Blue_Even  out  8 each  even-pixel colours.
- data_Red_Odd, data_Green_Odd, data_Blue_Odd  out  8 each  odd-pixel colours.
- col_Index  out  clog2(IMAGE_WIDTH/2)  pair index of the current output.
- row_Index  out  clog2(IMAGE_HEIGHT)  row of the current output.
- busy  out  1  high from the cycle after `start` is accepted until return to IDLE.
- sig_Frame_Done  out  1  one-cycle completion pulse.

## Operation
- FSM states: IDLE, ROW, BLANK, DONE.
- IDLE:
  - `start` moves to ROW.
  - Row and column counters clear to 0.
- ROW:
  - src_Ready = 1. This is the only state with src_Ready high.
  - Handshake = src_Valid & src_Ready.
  - On each handshake, capture src_Data into the six colour registers, latch col/row indices, and pulse horizontal_Pulse.
  - Column counter increments from 0 to IMAGE_WIDTH/2−1.
  - On the last pair of a row:
    - Column counter wraps to 0 and the row counter increments.
    - Next state is BLANK if rows remain and H_BLANK > 0.
    - Next state is ROW if rows remain and H_BLANK = 0.
    - Next state is DONE on the last row.
- BLANK: down-counter loaded with H_BLANK−1; move to ROW when it reads 0. src_Ready = 0.
- DONE: one cycle, then IDLE. `start` is ignored in DONE.
- Colour registers hold their last value between pulses.
- No handshake ⇒ no pulse. Stalls on src_Valid=0 are unbounded and lossless.
- `start` arriving while busy is dropped, not queued.
- `reset` at any cycle, including mid-row and in BLANK:
  - FSM goes to IDLE.
  - Counters, indices, colour outputs, horizontal_Pulse, busy and sig_Frame_Done all clear to 0 in the next cycle.
  - The partial frame is abandoned.

## Timing
- Reset values: all outputs 0 (src_Ready 0, since the FSM is in IDLE).
- `start` sampled at cycle t ⇒ state ROW and src_Ready=1 at t+1.
- Handshake at cycle t ⇒ horizontal_Pulse=1 with matching data and indices at t+1. Latency 1, registered outputs.
- Back-to-back handshakes ⇒ horizontal_Pulse stays high on consecutive cycles, one pair per cycle.
- Last row pair handshake at t with rows remaining ⇒ src_Ready=0 for exactly H_BLANK cycles (t+1 … t+H_BLANK), then src_Ready=1 again at t+H_BLANK+1.
- Final pair handshake at t:
  - Last horizontal_Pulse at t+1 (state DONE).
  - sig_Frame_Done=1 at t+2 only.
  - busy=0 from t+2.
  - A new `start` is accepted at t+2.
- Minimum frame duration: IMAGE_HEIGHT·IMAGE_WIDTH/2 + (IMAGE_HEIGHT−1)·H_BLANK + 3 cycles.

## Structure
- Shared package `threshold_pkg`:
  - pixel-pair struct (six 8-bit fields) and its 48-bit packing order;
  - FSM state enum;
  - BMP_HEADER_NUMBER constant (54).
- One sub-module, `frame_counter`:
  - column and row counters with load-zero, increment, `last_col` and `last_row` flags;
  - parameterised by IMAGE_WIDTH/2 and IMAGE_HEIGHT.
- Top level holds the FSM, blank counter and output registers.

## Test plan
All scenarios use IMAGE_WIDTH=8, IMAGE_HEIGHT=2, H_BLANK=2 unless stated.
- Full-rate frame:
  - Stimulus: src_Valid always 1; pair k carries R_even=k.
  - Response: 8 pulses with data 0..7; col_Index 0,1,2,3,0,1,2,3; row_Index 0×4 then 1×4.
  - Response: exactly 2 src_Ready=0 cycles between rows; sig_Frame_Done one cycle after the 8th pulse.
- Stall:
  - Stimulus: src_Valid toggles 1,0,1,0.
  - Response: pulses only on the cycle after each handshake; data order preserved; no duplicate or lost pairs.
- H_BLANK=0:
  - Response: 8 pulses with no src_Ready gap at the row boundary.
  - Response: frame length from `start` to sig_Frame_Done is 11 cycles.
- Start while busy:
  - Stimulus: `start` pulsed mid-row 0 and in DONE.
  - Response: no restart; exactly one sig_Frame_Done; next `start` after done runs a full second frame.
- Reset mid-operation:
  - Stimulus: reset asserted during row 1 (col 2) and, in a separate run, during BLANK.
  - Response: next cycle all outputs 0 and state IDLE; a subsequent `start` produces a full 8-pulse frame from col 0, row 0.
- Packing check:
  - Stimulus: src_Data = 48'h112233_445566.
  - Response: Red_Even=11, Green_Even=22, Blue_Even=33, Red_Odd=44, Green_Odd=55, Blue_Odd=66 on the pulse cycle.
